// File: rtl/icache_burst_mem_responder.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : icache_burst_mem_responder
// Description : Memory-side responder for instruction-cache line fills.
//               Accepts a single-cycle fill request, waits LATENCY cycles,
//               then streams mem_burst_len+1 incrementing words from a
//               backdoor-loadable word array. A throttle input can insert
//               gaps between beats.
// Revision    : 1.0 - initial release
// ============================================================================
module icache_burst_mem_responder #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int MEM_WORDS  = 4096,
    parameter int LEN_WIDTH  = 4,
    parameter int LATENCY    = 3
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         mem_req,
    input  logic [ADDR_WIDTH-1:0]        mem_addr,
    input  logic [LEN_WIDTH-1:0]         mem_burst_len,
    output logic                         mem_ready,
    output logic [DATA_WIDTH-1:0]        mem_data,
    output logic                         mem_valid,
    output logic                         mem_last,
    input  logic                         throttle,
    output logic                         req_dropped,
    input  logic                         init_we,
    input  logic [$clog2(MEM_WORDS)-1:0] init_addr,
    input  logic [DATA_WIDTH-1:0]        init_data
);

    localparam int IDX_W = $clog2(MEM_WORDS);
    localparam int REM_W = LEN_WIDTH + 1;
    // Two spare bits so the counter can always hold both LATENCY and 2.
    localparam int CNT_W = $clog2(LATENCY + 1) + 2;

    // IDLE accepts; WAIT burns latency cycles; BURST covers the final latency
    // cycle (where throttle already applies), all beat cycles and the
    // mem_last cycle, after which it returns to IDLE.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WAIT  = 2'd1,
        ST_BURST = 2'd2
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [DATA_WIDTH-1:0] mem_array [MEM_WORDS];

    logic [IDX_W-1:0] idx;
    logic [IDX_W-1:0] req_idx;
    logic [IDX_W-1:0] beat_idx;
    logic [REM_W-1:0] rem;
    logic [REM_W-1:0] req_rem;
    logic [REM_W-1:0] beat_rem;
    logic [CNT_W-1:0] lat_cnt;
    logic             accept;
    logic             emit;
    logic             unused_addr;

    // Word index; upper address bits alias, lower two bits are byte offset.
    assign req_idx     = mem_addr[IDX_W+1:2];
    assign req_rem     = {1'b0, mem_burst_len} + REM_W'(1);
    assign unused_addr = ^mem_addr;

    // Backing array: no reset so preloaded contents survive rst_n.
    always_ff @(posedge clk) begin
        if (init_we) begin
            mem_array[init_addr] <= init_data;
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode and beat selection; in IDLE a zero-latency request
    // emits its first beat straight from the incoming address.
    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        emit      = 1'b0;
        beat_idx  = idx;
        beat_rem  = rem;
        case (state)
            ST_IDLE: begin
                beat_idx = req_idx;
                beat_rem = req_rem;
                if (mem_req) begin
                    accept = 1'b1;
                    if (LATENCY == 0) begin
                        emit      = 1'b1;
                        state_nxt = ST_BURST;
                    end else if (LATENCY == 1) begin
                        state_nxt = ST_BURST;
                    end else begin
                        state_nxt = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                if (lat_cnt == CNT_W'(2)) begin
                    state_nxt = ST_BURST;
                end
            end
            ST_BURST: begin
                if (rem == '0) begin
                    state_nxt = ST_IDLE;
                end else if (!throttle) begin
                    emit = 1'b1;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // Burst bookkeeping and registered outputs; mem_data holds between beats.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx         <= '0;
            rem         <= '0;
            lat_cnt     <= '0;
            mem_data    <= '0;
            mem_valid   <= 1'b0;
            mem_last    <= 1'b0;
            mem_ready   <= 1'b1;
            req_dropped <= 1'b0;
        end else begin
            mem_valid   <= emit;
            mem_last    <= emit && (beat_rem == REM_W'(1));
            mem_ready   <= (state_nxt == ST_IDLE);
            req_dropped <= mem_req && (state != ST_IDLE);
            if (accept) begin
                idx     <= req_idx;
                rem     <= req_rem;
                lat_cnt <= CNT_W'(LATENCY);
            end else if (state == ST_WAIT) begin
                lat_cnt <= lat_cnt - 1'b1;
            end
            if (emit) begin
                mem_data <= mem_array[beat_idx];
                idx      <= beat_idx + 1'b1;
                rem      <= beat_rem - 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: doc/icache_burst_mem_responder.md
# icache_burst_mem_responder

Burst memory responder on the memory side of the instruction-cache fill interface. It accepts one single-cycle fill request (block address plus burst length), waits a programmable access latency, then streams `mem_burst_len+1` consecutive words with `mem_valid`, flagging the final beat with `mem_last`. A backdoor init port preloads the backing word array. An optional throttle input inserts beat gaps so benches can exercise the cache's fill path.

## Interface
- `ADDR_WIDTH`, 32, byte address width.
- `DATA_WIDTH`, 32, word width.
- `MEM_WORDS`, 4096, backing array depth in words; must be a power of 2.
- `LEN_WIDTH`, 4, width of `mem_burst_len`.
- `LATENCY`, 3, idle cycles between request acceptance and the first beat; 0 is legal.
- `clk  in  1  clock`
- `rst_n  in  1  reset, asynchronous, active-low`
- `mem_req  in  1  request strobe, single cycle, sampled at each clk rising edge`
- `mem_addr  in  ADDR_WIDTH  start byte address; bits [1:0] ignored`
- `mem_burst_len  in  LEN_WIDTH  beats minus one`
- `mem_ready  out  1  able to accept a request`
- `mem_data  out  DATA_WIDTH  beat data`
- `mem_valid  out  1  beat valid, one word per high cycle`
- `mem_last  out  1  final beat of burst, only with mem_valid`
- `throttle  in  1  suppress the beat that would appear next cycle`
- `req_dropped  out  1  one-cycle pulse: mem_req seen while busy`
- `init_we  in  1  backdoor word write enable`
- `init_addr  in  $clog2(MEM_WORDS)  backdoor word index`
- `init_data  in  DATA_WIDTH  backdoor write data`

## Operation
- Word index is `mem_addr[$clog2(MEM_WORDS)+1:2]`. Higher address bits are ignored, so addresses alias modulo `MEM_WORDS`.
- The FSM has three states:
  - IDLE: `mem_ready`=1. On `mem_req`, latch the word index, set beats remaining to `mem_burst_len+1` and the latency counter to `LATENCY`, then go to WAIT. If `LATENCY`=0, go directly to BURST.
  - WAIT: decrement the latency counter. Go to BURST once the first beat is due.
  - BURST: on each edge where `throttle`=0, drive `mem_data` from the array at the current index and assert `mem_valid`, then increment the index and decrement beats remaining.
    - The index increments modulo `MEM_WORDS`, so it wraps from `MEM_WORDS-1` to 0.
    - `mem_last`=1 on the beat where beats remaining reaches 0. The FSM returns to IDLE on that edge.
- The burst order is linear and incrementing from the start word. There is no critical-word-first ordering.
- A `mem_req` in WAIT or BURST is ignored. It is not queued, `req_dropped` pulses in the next cycle, and the active burst is unaffected.
- Init writes are honoured in any state.
  - The array is written at the clock edge.
  - A beat read on the same edge as a write to the same index returns the old value.
- `mem_data` holds the last beat value while `mem_valid`=0.
- Every `DATA_WIDTH` bit pattern is legal data. No arithmetic is performed on data.

## Timing
- All outputs are registered.
- Reset values: `mem_ready`=1, `mem_valid`=0, `mem_last`=0, `mem_data`=0, `req_dropped`=0. The state resets to IDLE.
- The backing array is not reset; its contents survive `rst_n`.
- Acceptance: `mem_req`=1 during cycle T with `mem_ready`=1.
  - `mem_ready`=0 from cycle T+1.
  - With no throttle, the first beat appears in cycle T+1+`LATENCY` and beats are back-to-back, so the last beat is in cycle T+1+`LATENCY`+`mem_burst_len`.
  - `mem_ready` returns to 1 in the cycle after the `mem_last` cycle.
  - The earliest next acceptance is that cycle.
- Throttle: `throttle`=1 during cycle c means no beat in cycle c+1. The beat shifts later and the data order is unchanged.
  - Throttle has no effect in IDLE.
  - Throttle has no effect in WAIT, except in the final WAIT cycle, where it delays the first beat.
- Reset asserted mid-burst: outputs take their reset values immediately and the burst is abandoned. After release the block is in IDLE with `mem_ready`=1.
- `mem_burst_len`=0 gives a single beat with `mem_valid` and `mem_last` high together.

## Test plan
- Basic burst:
  - Stimulus: preload indices 0x40–0x43 with 0xA0..0xA3; `LATENCY`=3; pulse `mem_req` in cycle T with `mem_addr`=0x100 and len=3.
  - Response: `mem_data` 0xA0, 0xA1, 0xA2, 0xA3 in cycles T+4..T+7; `mem_last` only in T+7; `mem_ready`=0 in T+1..T+7 and 1 in T+8.
- Throttle gap:
  - Stimulus: same setup as basic burst, with `throttle`=1 in cycle T+5.
  - Response: beats in T+4, T+5, T+7, T+8 carrying 0xA0..0xA3; `mem_valid`=0 in T+6; `mem_last` in T+8.
- Wrap-around:
  - Stimulus: `MEM_WORDS`=4096; preload indices 4094, 4095, 0, 1 with 1, 2, 3, 4; request `mem_addr`=0x3FF8 with len=3.
  - Response: data sequence 1, 2, 3, 4.
- Busy drop:
  - Stimulus: a second `mem_req` during the WAIT cycle T+2.
  - Response: `req_dropped`=1 in T+3 only; the original four beats are unchanged; no extra beats follow.
- Reset mid-burst:
  - Stimulus: assert `rst_n`=0 during the beat in T+5, then release.
  - Response: `mem_valid`=0 and `mem_ready`=1 immediately; a new request at `mem_addr`=0x100 returns 0xA0..0xA3, confirming the array is retained.
- Single beat with unaligned address:
  - Stimulus: `LATENCY`=0; `mem_addr`=0x103, len=0, in cycle T.
  - Response: one beat in T+1 with data 0xA0 (index 0x40), `mem_valid` and `mem_last` both high; `mem_ready`=1 in T+2.
